// File: rtl/apple_gen.sv
// Apple placement and eat detection for the snake game.
// Define APPLE_OCC_CHECK_EN to query the body map before placing an apple.
module apple_gen #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int X_BITS    = 6,
    parameter int Y_BITS    = 5,
    parameter int PULSE_CYC = 4
) (
    input  logic              CLK_50M,
    input  logic              RSTn,
    input  logic              game_run,
    input  logic              move_tick,
    input  logic [X_BITS-1:0] head_x,
    input  logic [Y_BITS-1:0] head_y,
    output logic              occ_req,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_ack,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] apple_x,
    output logic [Y_BITS-1:0] apple_y,
    output logic              apple_valid,
    output logic              add_cube
);

    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    // One extra bit so a grid edge equal to 2**X_BITS still compares correctly.
    localparam logic [X_BITS:0] GRID_W_C = GRID_W[X_BITS:0];
    localparam logic [Y_BITS:0] GRID_H_C = GRID_H[Y_BITS:0];

    typedef enum logic [1:0] {GEN, QUERY, ACTIVE, EAT} state_t;

    state_t             state, state_nxt;
    logic [15:0]        lfsr;
    logic [CNT_W-1:0]   cnt;
    logic [X_BITS-1:0]  cand_x;
    logic [Y_BITS-1:0]  cand_y;
    logic               cand_ok;
    logic               eat_hit;
    logic               place;

    assign cand_x  = lfsr[X_BITS-1:0];
    assign cand_y  = lfsr[X_BITS+Y_BITS-1:X_BITS];
    assign cand_ok = ({1'b0, cand_x} < GRID_W_C) && ({1'b0, cand_y} < GRID_H_C) &&
                     !((cand_x == head_x) && (cand_y == head_y));
    assign eat_hit = move_tick && game_run && (head_x == apple_x) && (head_y == apple_y);

    // Free-running; taps 16,14,13,11 give a maximal sequence that never hits 0.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) state <= GEN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GEN: begin
`ifdef APPLE_OCC_CHECK_EN
                if (cand_ok) state_nxt = QUERY;
`else
                if (cand_ok) state_nxt = ACTIVE;
`endif
            end
`ifdef APPLE_OCC_CHECK_EN
            QUERY: begin
                if (occ_ack) state_nxt = occ_hit ? GEN : ACTIVE;
            end
`endif
            ACTIVE: begin
                if (eat_hit) state_nxt = EAT;
            end
            EAT: begin
                if (cnt == '0) state_nxt = GEN;
            end
            default: state_nxt = GEN;
        endcase
    end

    always_comb begin
        add_cube    = (state == EAT);
        apple_valid = (state == ACTIVE);
`ifdef APPLE_OCC_CHECK_EN
        occ_req     = (state == QUERY);
`else
        occ_req     = 1'b0;
`endif
    end

`ifdef APPLE_OCC_CHECK_EN
    assign place = (state == QUERY) && occ_ack && !occ_hit;
`else
    logic unused_occ;
    assign unused_occ = occ_ack ^ occ_hit;
    assign place      = (state == GEN) && cand_ok;
`endif

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            occ_x <= '0;
            occ_y <= '0;
        end else if ((state == GEN) && cand_ok) begin
            occ_x <= cand_x;
            occ_y <= cand_y;
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            apple_x <= '0;
            apple_y <= '0;
        end else if (place) begin
`ifdef APPLE_OCC_CHECK_EN
            apple_x <= occ_x;
            apple_y <= occ_y;
`else
            apple_x <= cand_x;
            apple_y <= cand_y;
`endif
        end
    end

    // Pulse length counter: loaded on the eat, EAT ends when it reaches 0.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn)
            cnt <= '0;
        else if ((state == ACTIVE) && eat_hit)
            cnt <= CNT_W'(PULSE_CYC - 1);
        else if ((state == EAT) && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

endmodule

// File: doc/apple_gen.md
# apple_gen

Food generator and eat detector for the snake game. Places the apple on a random free grid cell, compares it against the snake head on every move, and on a hit raises the `add_cube` point strobe consumed by the score display. After each eat it relocates the apple, optionally querying the body map so the apple never lands on the snake. It sits between the snake movement logic and the score/display path.

## Interface
Parameters:
- `GRID_W`, 40, grid width in cells; valid x is 0..GRID_W-1.
- `GRID_H`, 30, grid height in cells; valid y is 0..GRID_H-1.
- `X_BITS`, 6, width of the x coordinate.
- `Y_BITS`, 5, width of the y coordinate.
- `PULSE_CYC`, 4, number of cycles `add_cube` is held high per eat (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `CLK_50M` in 1: system clock.
- `RSTn` in 1: asynchronous, active-low reset.
- `game_run` in 1: high while play is active; low freezes eat detection.
- `move_tick` in 1: one-cycle strobe; head coordinates are valid in this cycle.
- `head_x` in X_BITS: snake head x.
- `head_y` in Y_BITS: snake head y.
- `occ_req` out 1: body-map query request.
- `occ_x` out X_BITS: query cell x.
- `occ_y` out Y_BITS: query cell y.
- `occ_ack` in 1: query done; one-cycle strobe.
- `occ_hit` in 1: queried cell is occupied; valid only while `occ_ack` is high.
- `apple_x` out X_BITS: current apple x.
- `apple_y` out Y_BITS: current apple y.
- `apple_valid` out 1: apple placed and eatable.
- `add_cube` out 1: point strobe to the scorer.

## Operation
- 16-bit Fibonacci LFSR:
  - Taps 16,14,13,11; reset seed 16'hACE1.
  - Advances every clock in every state and never reaches zero.
- Candidate cell: x = lfsr[X_BITS-1:0], y = lfsr[X_BITS+Y_BITS-1:X_BITS].
- States:
  - GEN: `add_cube`=0, `apple_valid`=0. Sample the candidate.
    - Reject (stay in GEN, next cycle uses the new LFSR value) if x≥GRID_W, y≥GRID_H, or (x,y)==(head_x,head_y).
    - Otherwise latch the candidate into `occ_x`/`occ_y` and go to QUERY.
  - QUERY:
    - Drive `occ_req`=1 with `occ_x`/`occ_y` stable until `occ_ack` is sampled high.
    - In the ack cycle: if `occ_hit`=1, go to GEN; else copy the candidate to `apple_x`/`apple_y` and go to ACTIVE.
    - `occ_req` is low in the cycle after ack. An `occ_ack` received while `occ_req` is low is ignored.
  - ACTIVE: `apple_valid`=1.
    - On `move_tick` && `game_run` && head==apple: go to EAT and load the pulse counter with PULSE_CYC-1.
  - EAT: `add_cube`=1, `apple_valid`=0.
    - Counter decrements each cycle; at 0, go to GEN.
- `add_cube` therefore has a high time of exactly PULSE_CYC cycles and a low time of at least 2 cycles between pulses (GEN plus ≥1 QUERY/ACTIVE cycle). This satisfies a level-rearmed scorer: exactly one point per eat.
- `game_run`=0: ACTIVE ignores `move_tick`. GEN, QUERY and EAT continue, so an in-flight pulse and relocation still complete.
- `move_tick` outside ACTIVE is ignored; no eat is queued.
- `apple_x`/`apple_y` hold their last value outside ACTIVE and change only on the QUERY→ACTIVE transition.

## Timing
- Reset values: state=GEN; `add_cube`=0, `apple_valid`=0, `occ_req`=0; `occ_x`, `occ_y`, `apple_x`, `apple_y` = 0; LFSR=16'hACE1.
- Eat latency: `move_tick` sampled at edge N → `add_cube` high for cycles N+1..N+PULSE_CYC, and `apple_valid` low from N+1.
- Relocation latency: at least 1 GEN cycle + 1 QUERY cycle + the responder's ack latency. The block waits indefinitely for `occ_ack`.
- Reset mid-EAT or mid-QUERY: outputs return to reset values asynchronously; no partial pulse is extended.

## Configuration
- `APPLE_OCC_CHECK_EN` defined: QUERY state and the body-map handshake are built as described above.
- Not defined:
  - QUERY is removed; `occ_req` is tied 0 and `occ_x`/`occ_y` are still driven with the candidate.
  - `occ_ack`/`occ_hit` are unused.
  - An accepted GEN candidate goes straight to ACTIVE; first `apple_valid` comes 1 cycle after acceptance.

## Test plan
- Reset release, responder acks with hit=0 one cycle after req → first candidate inside 40×30 is placed; `apple_valid`=1; `apple_x`<40, `apple_y`<30.
- Apple at (5,7), `move_tick` with head (5,7), `game_run`=1 → `add_cube` high exactly 4 cycles starting the next cycle, then low; scorer model counts exactly 1.
- Same hit with `game_run`=0 → no `add_cube`, apple unchanged, `apple_valid` stays 1.
- Responder returns `occ_hit`=1 for the first 3 queries → 4 distinct `occ_req` handshakes, apple placed at the 4th candidate, `occ_req` never high during GEN.
- Assert `RSTn` low during the 2nd cycle of EAT → `add_cube` and `apple_valid` drop immediately; after release, normal placement resumes.
- Without `APPLE_OCC_CHECK_EN`: 100 consecutive eats → `occ_req` always 0, every apple in range and never equal to the head, 100 points counted.
